countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Down-counting BCD timer. It is the counterpart of the up-counting stopwatch datapath. The operator presets a 4-digit decimal value with per-digit increment pulses, starts the timer, and the value counts down once per tick to 0000. On reaching 0000 the block raises an alarm for a programmable number of ticks. The bcd output feeds the existing 7-segment digit decoders directly; the state output drives the board LEDs.

Parameters:
ALARM_TICKS, 5, number of tick strobes that done stays asserted after reaching 0000 (1..255)
TICKW, 8, width of internal alarm tick counter; must satisfy 2**TICKW > ALARM_TICKS

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
tick  input  1  one-cycle enable strobe from the clock divider (nominally 1 Hz), synchronous to clk
start  input  1  active-high start/resume request, already debounced, sampled every clk
stop  input  1  active-high pause request, sampled every clk
inc  input  1  active-high one-cycle pulse: increment the selected digit
sel  input  2  digit select for inc: 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands
clr  input  1  synchronous clear request
bcd  output  16  current value, 4 BCD digits; [3:0] ones … [15:12] thousands
state  output  4  one-hot state indicator: [0] IDLE, [1] RUN, [2] PAUSE, [3] DONE
done  output  1  alarm, high while in DONE

Behaviour:
- Reset (async, rst=1): bcd=16'h0000, state=4'b0001 (IDLE), done=0, alarm counter=0. Outputs hold while rst is high. First transition happens on the first clk edge after rst deasserts.
- All outputs are registered. Every input effect is visible on the clk edge that samples it (1-cycle latency).
- Priority in every state: clr > stop > start > tick > inc.
- clr, any state: bcd<=0000, go IDLE, done<=0, alarm counter<=0.
- IDLE:
  - start with bcd!=0000 -> RUN.
  - start with bcd==0000 -> stay IDLE; start is ignored.
  - inc -> selected digit <= (digit==9) ? 0 : digit+1. No carry into the neighbouring digit. Other digits unchanged.
  - tick is ignored.
- RUN:
  - stop -> PAUSE. A tick in the same cycle is discarded (no decrement).
  - tick -> decrement bcd by 1 in BCD. A digit 0 becomes 9 and borrows from the next digit.
  - tick with bcd==0001 -> bcd<=0000, go DONE, done<=1, alarm counter<=0.
  - inc is ignored.
  - start is a no-op.
- PAUSE:
  - start with bcd!=0000 -> RUN.
  - start with bcd==0000 -> IDLE.
  - inc edits digits exactly as in IDLE.
  - tick is ignored.
- DONE:
  - bcd holds 0000 and done=1.
  - Each tick increments the alarm counter. On the tick where the counter reaches ALARM_TICKS-1: go IDLE, done<=0 on that edge. done is therefore high for exactly ALARM_TICKS ticks.
  - start in DONE acknowledges early: go IDLE, done<=0.
  - inc and stop are ignored.
- Digit integrity: bcd digits never hold values 10..15. If an illegal encoding is ever present, the next decrement or inc forces that digit to 0.
- Decrement is never applied at 0000. RUN is never entered with 0000 and is left at the 0001->0000 tick.
- Illegal state encoding -> IDLE on the next clk, bcd unchanged.

Test Plan:
- Reset then idle: assert rst mid-RUN with bcd=0042 -> bcd=0000, state=0001, done=0 immediately without a clk edge. No change for 20 ticks after release.
- Preset: in IDLE, sel=0 inc ×3, sel=1 inc ×12 -> bcd=0023 (tens wraps 9->0->2, no carry). Then start with bcd=0000 after clr -> remains IDLE.
- Borrow chain: preset 1000, start, 1 tick -> 0999. 2 more ticks -> 0997. state=0010 throughout.
- Pause/resume: RUN at 0050, stop and tick in the same cycle -> PAUSE, bcd=0050. 5 ticks -> unchanged. start, 1 tick -> 0049.
- Expiry and alarm: preset 0002, start, 2 ticks -> bcd=0000, state=1000, done=1. With ALARM_TICKS=5, done drops on the 5th following tick -> IDLE. Repeat with start after 2 ticks -> IDLE on that clk.
- clr dominance: in DONE, assert clr, start and tick together -> IDLE, bcd=0000, done=0 after one clk.

Source files
------------

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Four-digit BCD down-counter with an alarm phase. The operator presets the
// value digit by digit with inc/sel, starts it, and the value decrements once
// per tick strobe. When it reaches 0000, done is raised for ALARM_TICKS tick
// strobes. Alternatively, a start press acknowledges the alarm early.
//
// Parameters:
//   ALARM_TICKS : tick strobes that done stays high after expiry (1..255)
//   TICKW       : width of the alarm tick counter (2**TICKW > ALARM_TICKS)
//
// Ports:
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   tick  : one-cycle enable strobe from the clock divider
//   start : start / resume / alarm-acknowledge request (level, sampled every clk)
//   stop  : pause request (level, sampled every clk)
//   inc   : one-cycle pulse, increments the digit chosen by sel (no carry)
//   sel   : digit select for inc: 0 ones, 1 tens, 2 hundreds, 3 thousands
//   clr   : synchronous clear to 0000 / IDLE
//   bcd   : current value, [3:0] ones ... [15:12] thousands
//   state : one-hot FSM state, [0] IDLE [1] RUN [2] PAUSE [3] DONE
//   done  : alarm, high while in DONE
//
// The input priority, applied in every state, is clr > stop > start > tick > inc.
// An input that a state explicitly ignores does not mask lower-priority inputs.
// For example, a start that is held while RUN is active still lets ticks through.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module countdown_timer #(
   parameter int ALARM_TICKS = 5,
   parameter int TICKW       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic        stop,
   input  logic        inc,
   input  logic [1:0]  sel,
   input  logic        clr,
   output logic [15:0] bcd,
   output logic [3:0]  state,
   output logic        done
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_RUN   = 4'b0010,
      S_PAUSE = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   localparam logic [TICKW-1:0] ALARM_LAST = TICKW'(ALARM_TICKS - 1);

   state_t            state_q, state_d;
   logic [15:0]       bcd_q, bcd_d;
   logic              done_q, done_d;
   logic [TICKW-1:0]  alarm_q, alarm_d;

   logic              is_zero;
   logic              is_one;

   assign is_zero = (bcd_q == 16'h0000);
   assign is_one  = (bcd_q == 16'h0001);

   // Single-digit increment that wraps 9 -> 0. An illegal code 10..15 is
   // forced to 0 so that the digit recovers on the next edit.
   function automatic logic [3:0] digit_inc(input logic [3:0] d);
      logic [3:0] r;
      if (d >= 4'd9) r = 4'd0;
      else           r = d + 4'd1;
      return r;
   endfunction

   // Increment only the selected digit; neighbours are untouched (no carry).
   function automatic logic [15:0] bcd_edit(input logic [15:0] v,
                                            input logic [1:0]  s);
      logic [15:0] r;
      r = v;
      case (s)
         2'd0:    r[3:0]   = digit_inc(v[3:0]);
         2'd1:    r[7:4]   = digit_inc(v[7:4]);
         2'd2:    r[11:8]  = digit_inc(v[11:8]);
         default: r[15:12] = digit_inc(v[15:12]);
      endcase
      return r;
   endfunction

   // Four-digit BCD decrement with a borrow chain from the ones digit upward.
   // A digit at 0 that receives a borrow becomes 9 and passes the borrow on.
   // An illegal digit that receives a borrow is forced to 0 and absorbs the
   // borrow. The caller never applies this to 0000.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      logic [3:0]  d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = v[i*4 +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
               borrow      = 1'b1;
            end else if (d > 4'd9) begin
               r[i*4 +: 4] = 4'd0;
               borrow      = 1'b0;
            end else begin
               r[i*4 +: 4] = d - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bcd_q   <= 16'h0000;
         done_q  <= 1'b0;
         alarm_q <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
         alarm_q <= alarm_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      done_d  = done_q;
      alarm_d = alarm_q;

      if (clr) begin
         state_d = S_IDLE;
         bcd_d   = 16'h0000;
         done_d  = 1'b0;
         alarm_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_d = 1'b0;
               // While stop is held, it masks start and inc. Ticks never
               // affect IDLE.
               if (!stop) begin
                  if (start && !is_zero) begin
                     state_d = S_RUN;
                  end else if (inc) begin
                     bcd_d = bcd_edit(bcd_q, sel);
                  end
               end
            end

            S_RUN: begin
               done_d = 1'b0;
               if (stop) begin
                  // The pause wins, and a tick in the same cycle is dropped.
                  state_d = S_PAUSE;
               end else if (tick) begin
                  // The last step lands on 0000. A zero value here cannot
                  // normally occur; if it does, the state goes straight to
                  // DONE without a decrement.
                  if (is_one || is_zero) begin
                     bcd_d   = 16'h0000;
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     alarm_d = '0;
                  end else begin
                     bcd_d = bcd_dec(bcd_q);
                  end
               end
            end

            S_PAUSE: begin
               done_d = 1'b0;
               if (!stop) begin
                  if (start) begin
                     // If the operator has edited the value down to 0000, a
                     // resume is pointless, so the FSM returns to IDLE.
                     state_d = is_zero ? S_IDLE : S_RUN;
                  end else if (inc) begin
                     bcd_d = bcd_edit(bcd_q, sel);
                  end
               end
            end

            S_DONE: begin
               bcd_d  = 16'h0000;
               done_d = 1'b1;
               if (start) begin
                  state_d = S_IDLE;
                  done_d  = 1'b0;
                  alarm_d = '0;
               end else if (tick) begin
                  // The counter is 0 on entry. The tick that finds it at
                  // ALARM_TICKS-1 ends the alarm, which is the ALARM_TICKS-th
                  // tick after expiry.
                  if (alarm_q >= ALARM_LAST) begin
                     state_d = S_IDLE;
                     done_d  = 1'b0;
                     alarm_d = '0;
                  end else begin
                     alarm_d = alarm_q + 1'b1;
                  end
               end
            end

            default: begin
               // Unreachable one-hot code: recover to IDLE and keep the value.
               state_d = S_IDLE;
               done_d  = 1'b0;
               alarm_d = '0;
            end
         endcase
      end
   end

   assign bcd   = bcd_q;
   assign state = state_q;
   assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer with ALARM_TICKS = 5. Inputs change 1 ns
// after a rising edge and are sampled by the next rising edge. Outputs are
// checked 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int ALARM_TICKS = 5;

   localparam logic [3:0] ST_IDLE  = 4'b0001;
   localparam logic [3:0] ST_RUN   = 4'b0010;
   localparam logic [3:0] ST_PAUSE = 4'b0100;
   localparam logic [3:0] ST_DONE  = 4'b1000;

   logic        clk;
   logic        rst;
   logic        tick;
   logic        start;
   logic        stop;
   logic        inc;
   logic [1:0]  sel;
   logic        clr;
   logic [15:0] bcd;
   logic [3:0]  state;
   logic        done;

   int passed;
   int total;

   countdown_timer #(.ALARM_TICKS(ALARM_TICKS), .TICKW(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .start (start),
      .stop  (stop),
      .inc   (inc),
      .sel   (sel),
      .clr   (clr),
      .bcd   (bcd),
      .state (state),
      .done  (done)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Present one cycle of inputs, let one rising edge sample them, and return
   // 1 ns after that edge with all inputs back at idle.
   task automatic drive(input logic st, input logic sp, input logic tk,
                        input logic in, input logic [1:0] sl, input logic cl);
      start = st;
      stop  = sp;
      tick  = tk;
      inc   = in;
      sel   = sl;
      clr   = cl;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      tick  = 1'b0;
      inc   = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic press_inc(input logic [1:0] s, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, s, 1'b0);
   endtask

   // Each tick is followed by a quiet cycle, as a real divider strobe would be.
   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
         drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      end
   endtask

   task automatic do_start;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic do_clr;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bcd !== 16'h0000) $display("FAIL reset_bcd: got %h want %h", bcd, 16'h0000); else passed++;
      total++; if (state !== ST_IDLE) $display("FAIL reset_state: got %b want %b", state, ST_IDLE); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      // Preset 0042 and run, then reset between clock edges.
      press_inc(2'd0, 2);
      press_inc(2'd1, 4);
      do_start;
      total++; if (state !== ST_RUN) $display("FAIL reset_pre_run: got %b want %b", state, ST_RUN); else passed++;
      total++; if (bcd !== 16'h0042) $display("FAIL reset_pre_bcd: got %h want %h", bcd, 16'h0042); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (bcd !== 16'h0000) $display("FAIL async_bcd: got %h want %h", bcd, 16'h0000); else passed++;
      total++; if (state !== ST_IDLE) $display("FAIL async_state: got %b want %b", state, ST_IDLE); else passed++;
      total++; if (done !== 1'b0) $display("FAIL async_done: got %b want 0", done); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_ticks(20);
      total++; if (bcd !== 16'h0000) $display("FAIL idle_ticks_bcd: got %h want %h", bcd, 16'h0000); else passed++;
      total++; if (state !== ST_IDLE) $display("FAIL idle_ticks_state: got %b want %b", state, ST_IDLE); else passed++;
   endtask

   task automatic test_preset;
      do_clr;
      press_inc(2'd0, 3);
      press_inc(2'd1, 12);
      total++; if (bcd !== 16'h0023) $display("FAIL preset_bcd: got %h want %h", bcd, 16'h0023); else passed++;
      // In IDLE, a tick is ignored and an inc in the same cycle still applies.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
      total++; if (bcd !== 16'h0123) $display("FAIL preset_tick_inc: got %h want %h", bcd, 16'h0123); else passed++;
      do_clr;
      total++; if (bcd !== 16'h0000) $display("FAIL preset_clr: got %h want %h", bcd, 16'h0000); else passed++;
      do_start;
      total++; if (state !== ST_IDLE) $display("FAIL start_zero_state: got %b want %b", state, ST_IDLE); else passed++;
   endtask

   task automatic test_borrow;
      do_clr;
      press_inc(2'd3, 1);
      do_start;
      total++; if (state !== ST_RUN) $display("FAIL borrow_run: got %b want %b", state, ST_RUN); else passed++;
      do_ticks(1);
      total++; if (bcd !== 16'h0999) $display("FAIL borrow_chain: got %h want %h", bcd, 16'h0999); else passed++;
      total++; if (state !== ST_RUN) $display("FAIL borrow_state1: got %b want %b", state, ST_RUN); else passed++;
      do_ticks(2);
      total++; if (bcd !== 16'h0997) $display("FAIL borrow_two_more: got %h want %h", bcd, 16'h0997); else passed++;
      total++; if (state !== ST_RUN) $display("FAIL borrow_state2: got %b want %b", state, ST_RUN); else passed++;
      // In RUN, inc is ignored.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      total++; if (bcd !== 16'h0997) $display("FAIL run_inc_ignored: got %h want %h", bcd, 16'h0997); else passed++;
      // A start held while running does not block the tick.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      total++; if (bcd !== 16'h0996) $display("FAIL run_start_tick: got %h want %h", bcd, 16'h0996); else passed++;
   endtask

   task automatic test_pause;
      do_clr;
      press_inc(2'd1, 5);
      do_start;
      total++; if (bcd !== 16'h0050) $display("FAIL pause_preset: got %h want %h", bcd, 16'h0050); else passed++;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      total++; if (state !== ST_PAUSE) $display("FAIL pause_state: got %b want %b", state, ST_PAUSE); else passed++;
      total++; if (bcd !== 16'h0050) $display("FAIL pause_tick_dropped: got %h want %h", bcd, 16'h0050); else passed++;
      do_ticks(5);
      total++; if (bcd !== 16'h0050) $display("FAIL pause_hold: got %h want %h", bcd, 16'h0050); else passed++;
      total++; if (state !== ST_PAUSE) $display("FAIL pause_hold_state: got %b want %b", state, ST_PAUSE); else passed++;
      do_start;
      total++; if (state !== ST_RUN) $display("FAIL resume_state: got %b want %b", state, ST_RUN); else passed++;
      do_ticks(1);
      total++; if (bcd !== 16'h0049) $display("FAIL resume_tick: got %h want %h", bcd, 16'h0049); else passed++;

      // Edit the value to 0000 while paused. The resume then returns to IDLE.
      do_clr;
      press_inc(2'd0, 5);
      do_start;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      press_inc(2'd0, 5);
      total++; if (bcd !== 16'h0000) $display("FAIL pause_edit_wrap: got %h want %h", bcd, 16'h0000); else passed++;
      do_start;
      total++; if (state !== ST_IDLE) $display("FAIL pause_start_zero: got %b want %b", state, ST_IDLE); else passed++;
   endtask

   task automatic test_expiry;
      do_clr;
      press_inc(2'd0, 2);
      do_start;
      do_ticks(1);
      total++; if (bcd !== 16'h0001) $display("FAIL expiry_step: got %h want %h", bcd, 16'h0001); else passed++;
      do_ticks(1);
      total++; if (bcd !== 16'h0000) $display("FAIL expiry_bcd: got %h want %h", bcd, 16'h0000); else passed++;
      total++; if (state !== ST_DONE) $display("FAIL expiry_state: got %b want %b", state, ST_DONE); else passed++;
      total++; if (done !== 1'b1) $display("FAIL expiry_done: got %b want 1", done); else passed++;
      // In DONE, inc and stop are ignored.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      total++; if (bcd !== 16'h0000) $display("FAIL done_inc_ignored: got %h want %h", bcd, 16'h0000); else passed++;
      do_ticks(ALARM_TICKS - 1);
      total++; if (state !== ST_DONE) $display("FAIL alarm_hold_state: got %b want %b", state, ST_DONE); else passed++;
      total++; if (done !== 1'b1) $display("FAIL alarm_hold_done: got %b want 1", done); else passed++;
      do_ticks(1);
      total++; if (state !== ST_IDLE) $display("FAIL alarm_end_state: got %b want %b", state, ST_IDLE); else passed++;
      total++; if (done !== 1'b0) $display("FAIL alarm_end_done: got %b want 0", done); else passed++;

      // Early acknowledge with start.
      press_inc(2'd0, 2);
      do_start;
      do_ticks(2);
      total++; if (state !== ST_DONE) $display("FAIL ack_pre_state: got %b want %b", state, ST_DONE); else passed++;
      do_ticks(2);
      do_start;
      total++; if (state !== ST_IDLE) $display("FAIL ack_state: got %b want %b", state, ST_IDLE); else passed++;
      total++; if (done !== 1'b0) $display("FAIL ack_done: got %b want 0", done); else passed++;
   endtask

   task automatic test_clr_dominance;
      do_clr;
      press_inc(2'd0, 1);
      do_start;
      do_ticks(1);
      total++; if (state !== ST_DONE) $display("FAIL clr_pre_state: got %b want %b", state, ST_DONE); else passed++;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
      total++; if (state !== ST_IDLE) $display("FAIL clr_state: got %b want %b", state, ST_IDLE); else passed++;
      total++; if (bcd !== 16'h0000) $display("FAIL clr_bcd: got %h want %h", bcd, 16'h0000); else passed++;
      total++; if (done !== 1'b0) $display("FAIL clr_done: got %b want 0", done); else passed++;
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b0;
      tick   = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      inc    = 1'b0;
      sel    = 2'd0;
      clr    = 1'b0;
      #1;
      test_reset;
      test_preset;
      test_borrow;
      test_pause;
      test_expiry;
      test_clr_dominance;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
